// File: rtl/led_anim_pkg.sv
// Shared encodings for the LED pattern engine.
//   MODE_*  : values of the 2-bit mode selector
//   DIR_*   : direction flag meaning; LEFT/UP and RIGHT/DOWN share a bit
//             because a given pattern only ever uses one pair.
package led_anim_pkg;

  localparam logic [1:0] MODE_BOUNCE = 2'd0;
  localparam logic [1:0] MODE_ROTATE = 2'd1;
  localparam logic [1:0] MODE_FILL   = 2'd2;
  localparam logic [1:0] MODE_BLINK  = 2'd3;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_DOWN  = 1'b1;

endpackage

// File: rtl/led_animator_tick_gen.sv
// Prescaler for the LED pattern engine.
// Ports:
//   iCLK    - clock
//   iRST_N  - synchronous active-low reset
//   en      - count enable; 0 freezes cnt
//   clr     - zero cnt (wins over counting)
//   period  - tick asserts once cnt reaches period, i.e. every period+1 enabled cycles
//   tick    - combinational step request: en & (cnt >= period)
module tick_gen #(
  parameter int PRESC_W = 26
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] period,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt_q, cnt_d;

  // >= rather than == so a period lowered below the running count still
  // fires on the next enabled edge instead of wrapping the counter.
  assign tick = en & (cnt_q >= period);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + PRESC_W'(1);
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_animator.sv
// Selectable LED pattern generator (bounce / rotate / bar-fill / blink).
// Ports:
//   iCLK, iRST_N - clock and synchronous active-low reset
//   en           - 1 runs the prescaler and pattern, 0 freezes both
//   mode         - pattern select (see led_anim_pkg); a change restarts the pattern
//   period       - one step every period+1 enabled cycles
//   leds         - registered pattern
//   step         - pulse in the cycle a new pattern first shows on leds
//   wrap         - pulse when the pattern is back at its start state
module led_animator
  import led_anim_pkg::*;
#(
  parameter int WIDTH   = 18,
  parameter int PRESC_W = 26
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [PRESC_W-1:0] period,
  output logic [WIDTH-1:0]   leds,
  output logic               step,
  output logic               wrap
);

  localparam int                LVL_W   = $clog2(WIDTH + 1);
  localparam logic [LVL_W-1:0]  LVL_MAX = LVL_W'(WIDTH);
  localparam logic [WIDTH-1:0]  BIT0    = WIDTH'(1);

  logic [WIDTH-1:0] leds_q, leds_d;
  logic [1:0]       mode_q, mode_d;
  logic             dir_q, dir_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;

  logic restart;
  logic tick;
  logic advance;

  assign restart = (mode != mode_q);
  // Restart outranks a pending tick; the prescaler is cleared in that cycle.
  assign advance = tick & ~restart;

  tick_gen #(
    .PRESC_W (PRESC_W)
  ) u_tick_gen (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .en     (en),
    .clr    (restart),
    .period (period),
    .tick   (tick)
  );

  always_comb begin
    leds_d  = leds_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    level_d = level_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;

    if (restart) begin
      mode_d  = mode;
      dir_d   = DIR_LEFT;
      level_d = '0;
      leds_d  = (mode == MODE_BOUNCE || mode == MODE_ROTATE) ? BIT0 : '0;
    end else if (advance) begin
      step_d = 1'b1;
      case (mode_q)
        MODE_BOUNCE: begin
          if (dir_q == DIR_LEFT && leds_q[WIDTH-1]) begin
            dir_d  = DIR_RIGHT;
            leds_d = leds_q >> 1;
          end else if (dir_q == DIR_RIGHT && leds_q[0]) begin
            dir_d  = DIR_LEFT;
            leds_d = leds_q << 1;
          end else if (dir_q == DIR_LEFT) begin
            leds_d = leds_q << 1;
          end else begin
            leds_d = leds_q >> 1;
          end
          wrap_d = (leds_d == BIT0);
        end
        MODE_ROTATE: begin
          leds_d = {leds_q[WIDTH-2:0], leds_q[WIDTH-1]};
          wrap_d = (leds_d == BIT0);
        end
        MODE_FILL: begin
          if (dir_q == DIR_UP) begin
            if (level_q == LVL_MAX) begin
              dir_d   = DIR_DOWN;
              level_d = level_q - LVL_W'(1);
            end else begin
              level_d = level_q + LVL_W'(1);
            end
          end else begin
            level_d = level_q - LVL_W'(1);
            if (level_q == LVL_W'(1)) dir_d = DIR_UP;
          end
          // Thermometer: low level_d bits lit.
          for (int i = 0; i < WIDTH; i++) begin
            leds_d[i] = (LVL_W'(i) < level_d);
          end
          wrap_d = (level_d == '0);
        end
        MODE_BLINK: begin
          leds_d = ~leds_q;
          wrap_d = (leds_q == '1);
        end
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      leds_q  <= BIT0;
      mode_q  <= MODE_BOUNCE;
      dir_q   <= DIR_LEFT;
      level_q <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      leds_q  <= leds_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      level_q <= level_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
    end
  end

  assign leds = leds_q;
  assign step = step_q;
  assign wrap = wrap_q;

endmodule

// File: doc/led_animator.md
# led_animator

Parametrised LED pattern generator driving the board's LEDR/LEDG banks from a single clock, replacing the fixed 18-bit bounce animation with a selectable-mode, rate-programmable engine. It sits beside the register-file/ULA datapath in the top level, taking its mode and rate from switches and its enable from a key. Four patterns are supported: bounce, rotate, bar-fill and blink. Each pattern advances one step per prescaler tick, and the block emits step and wrap pulses for chaining or display.

## Interface
- `WIDTH`, default 18: number of LED outputs; legal range ≥ 2.
- `PRESC_W`, default 26: width of the prescaler counter and of the `period` input.
- `iCLK` input, 1 bit: the only clock; all state changes on its rising edge.
- `iRST_N` input, 1 bit: reset, synchronous and active-low.
- `en` input, 1 bit: 1 = run; 0 = freeze the prescaler and the pattern.
- `mode` input, 2 bits: 0 BOUNCE, 1 ROTATE, 2 FILL, 3 BLINK.
- `period` input, `PRESC_W` bits: a step occurs every `period+1` enabled cycles.
- `leds` output, `WIDTH` bits: the registered pattern.
- `step` output, 1 bit: one-cycle pulse in the same cycle the new pattern first appears on `leds`.
- `wrap` output, 1 bit: one-cycle pulse when the pattern returns to its start state.

## Operation
- **Reset** (`iRST_N`=0 at an edge):
  - `cnt`=0, `mode_q`=BOUNCE, `dir`=LEFT, `level`=0.
  - `leds`=1 (bit 0 lit), `step`=0, `wrap`=0.
- **Priority each edge**: reset > restart > step > hold.
- **Restart**: taken when `mode` ≠ `mode_q`, regardless of `en`.
  - `mode_q`←`mode`, `cnt`←0, pattern loads the start state of the new mode.
  - `step`=0 and `wrap`=0 on a restart cycle.
- **Step**: taken when `en`=1 and `cnt` ≥ `period`.
  - `cnt`←0, pattern advances one step, `step`←1.
  - The `≥` comparison covers `period` being lowered below `cnt` mid-count; such a case steps on the next enabled edge.
- **Count**: when `en`=1 and `cnt` < `period`, `cnt`←`cnt`+1; `step`=`wrap`=0.
- **Hold**: when `en`=0 and no restart, all state holds; `step`=`wrap`=0.
- **BOUNCE**: start state `leds`=1, `dir`=LEFT.
  - On a step: if `dir`=LEFT and `leds[WIDTH-1]`=1, set `dir`=RIGHT and shift right.
  - Else if `dir`=RIGHT and `leds[0]`=1, set `dir`=LEFT and shift left.
  - Else shift in `dir`.
  - Cycle length is 2·(WIDTH−1) steps; `wrap` fires on the step that produces `leds`=1.
- **ROTATE**: start state `leds`=1; each step rotates left, so bit WIDTH−1 moves to bit 0.
  - `wrap` fires on the step that produces `leds`=1.
  - Cycle length is WIDTH steps.
- **FILL**: start state `level`=0, `dir`=UP, `leds`=0.
  - `leds` is a thermometer code with the low `level` bits set.
  - UP increments `level` to WIDTH, then DOWN decrements it to 0, where `dir` returns to UP.
  - `wrap` fires on the step that produces `level`=0.
  - Cycle length is 2·WIDTH steps.
- **BLINK**: start state `leds`=0; each step inverts all bits.
  - `wrap` fires on the step that produces all-zero.
- **Invariant**: exactly one bit is set in BOUNCE and ROTATE at all times. Any state violating this is unreachable; no recovery logic is required.

## Timing
- Step latency: with `en` held at 1 from `cnt`=0, the pattern changes at edge `period+1`. That gives `step` period `period+1` cycles; `period`=0 steps every cycle.
- `leds`, `step` and `wrap` are all registered, with no combinational path from inputs to outputs.
- Restart takes effect at the first edge where `mode` differs from `mode_q`. The first step in the new mode occurs `period+1` enabled cycles later.
- Reset mid-pattern: at the next edge the outputs equal their reset values and the mode is BOUNCE. If `mode` ≠ 0, a restart follows on the next edge.
- `en` deasserted on the same edge a step would occur: no step, `cnt` holds at its value.

## Structure
- Package `led_anim_pkg` holds:
  - the mode encoding (`MODE_BOUNCE`=0, `MODE_ROTATE`=1, `MODE_FILL`=2, `MODE_BLINK`=3);
  - the direction constants `DIR_LEFT`/`DIR_UP`=0 and `DIR_RIGHT`/`DIR_DOWN`=1.
- Sub-module `tick_gen` (parameter `PRESC_W`; ports `iCLK`, `iRST_N`, `en`, `clr`, `period`, `tick`) holds the `cnt` prescaler.
  - `tick` is combinational, equal to `en` & (`cnt` ≥ `period`).
  - `clr` zeroes `cnt`.
- `led_animator` holds the pattern registers, `mode_q`, `dir`, `level`, and the registered `step`/`wrap`.

## Test plan
- **Reset and bounce**: WIDTH=4, `period`=0, `mode`=0, `en`=1 after reset. `leds` must read 0001, 0010, 0100, 1000, 0100, 0010, 0001. `wrap` is high only on the cycle showing the final 0001.
- **Prescale**: `period`=2, ROTATE, WIDTH=4. `step` pulses every 3 cycles and `leds` runs 0001→0010→0100→1000→0001. `wrap` fires with the last 0001, 12 cycles after start.
- **Fill and blink**: WIDTH=4, `period`=0.
  - FILL sequence is 0000, 0001, 0011, 0111, 1111, 0111, 0011, 0001, 0000, with `wrap` on the last 0000.
  - BLINK alternates 0000/1111, with `wrap` on each 0000.
- **Enable freeze**: drop `en` for 5 cycles mid-pattern with `period`=3. `leds` and `cnt` hold with no pulses. On re-enable, the remaining count completes before the next step.
- **Mode change and period shrink**:
  - Switch to FILL while in BOUNCE at 0100: next edge `leds`=0000, with `step`=`wrap`=0.
  - Lower `period` from 10 to 1 at `cnt`=5: a step occurs on the next enabled edge.
- **Synchronous reset**: assert `iRST_N`=0 for 1 cycle in BLINK while `leds`=1111. The next edge gives `leds`=0001 (BOUNCE start), then a restart to BLINK gives 0000.
